// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared types, constants and decode helper for decode_queue
//
// Purpose: queue entry / decode-info / FSQ tag types, default widths, and the
// per-lane instruction decoder used by decode_queue.
// Ports: none (package).
// Optional feature macro used by decode_queue: DECQ_BYPASS_EN.

package decode_queue_pkg;

  localparam int DECODE_WIDTH = 4;
  localparam int DECQ_DEPTH   = 16;
  localparam int DECQ_PTR_W   = $clog2(DECQ_DEPTH) + 1;

  // Queue pointer for the default depth; the extra MSB is the wrap bit.
  typedef logic [DECQ_PTR_W-1:0] decq_ptr_t;

  typedef enum logic [2:0] {
    FU_NONE = 3'd0,
    FU_ALU  = 3'd1,
    FU_MDU  = 3'd2,
    FU_BRU  = 3'd3,
    FU_LDU  = 3'd4,
    FU_STU  = 3'd5,
    FU_CSR  = 3'd6
  } fu_t;

  typedef struct packed {
    fu_t        fu;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_wen;
    logic       illegal;
    logic       exc_iam;
    logic       exc_ipf;
  } decode_info_t;

  typedef struct packed {
    logic [5:0] idx;
    logic [3:0] offset;
  } fsq_idx_info_t;

  typedef struct packed {
    decode_info_t  di;
    logic [31:0]   inst;
    fsq_idx_info_t fsq_info;
  } decq_entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // A fetch fault means the instruction bits are garbage, so no unit or
  // destination is claimed and the op only carries its exception flags.
  function automatic decode_info_t decode_inst(input logic [31:0] inst,
                                               input logic        iam,
                                               input logic        ipf);
    decode_info_t di;
    logic         writes_rd;
    di         = '0;
    writes_rd  = 1'b0;
    di.rd      = inst[11:7];
    di.rs1     = inst[19:15];
    di.rs2     = inst[24:20];
    di.exc_iam = iam;
    di.exc_ipf = ipf;
    case (inst[6:0])
      OPC_OP: begin
        di.fu     = (inst[31:25] == F7_MULDIV) ? FU_MDU : FU_ALU;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
        di.fu     = FU_ALU;
        writes_rd = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        di.fu     = FU_BRU;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: di.fu = FU_BRU;
      OPC_LOAD: begin
        di.fu     = FU_LDU;
        writes_rd = 1'b1;
      end
      OPC_STORE: di.fu = FU_STU;
      OPC_SYSTEM: begin
        di.fu     = FU_CSR;
        writes_rd = 1'b1;
      end
      default: di.illegal = 1'b1;
    endcase
    if (iam || ipf) begin
      di.fu      = FU_NONE;
      di.illegal = 1'b0;
      writes_rd  = 1'b0;
    end
    di.rd_wen = writes_rd && (di.rd != 5'd0);
    return di;
  endfunction

endpackage

// File: rtl/decode_queue_compact.sv
// rtl/decode_queue_compact.sv - lane-mask prefix counter for compacting valid lanes
//
// Purpose: for each lane, the number of set mask bits below it (its slot in
// the compacted bundle), plus the total number of set bits.
// Ports:
//   mask   in  N            lane valid mask
//   offset out N x CW       popcount(mask[i-1:0]) per lane
//   total  out CW           popcount(mask)

module decq_compact
  import decode_queue_pkg::*;
#(
  parameter int N  = DECODE_WIDTH,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         mask,
  output logic [N-1:0][CW-1:0] offset,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = acc;
      acc       = acc + CW'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode stage with elastic compacting queue toward rename
//
// Purpose: decodes up to IN_WIDTH fetched lanes per cycle, compacts valid
// lanes in program order into a circular queue, and presents up to
// OUT_WIDTH decoded ops per cycle from a registered output stage.
// Optional feature macro: DECQ_BYPASS_EN (empty queue loads the output
// register straight from the incoming bundle).
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   in_en/in_inst/in_iam/in_ipf      fetch lanes (holes allowed)
//   in_fsq_info                      FSQ tag per lane
//   in_ready                         bundle is accepted this cycle
//   out_en/out_di/out_inst/out_fsq_info  registered ops to rename (prefix valid)
//   out_stall                        hold the output stage
//   redirect, walk                   flush everything
//   perf_walk_stall                  registered walk && in_en[0]

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int IN_WIDTH  = DECODE_WIDTH,
  parameter int OUT_WIDTH = DECODE_WIDTH,
  parameter int DEPTH     = DECQ_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_WIDTH-1:0]            in_en,
  input  logic [IN_WIDTH-1:0][31:0]      in_inst,
  input  logic [IN_WIDTH-1:0]            in_iam,
  input  logic [IN_WIDTH-1:0]            in_ipf,
  input  fsq_idx_info_t [IN_WIDTH-1:0]   in_fsq_info,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           out_en,
  output decode_info_t [OUT_WIDTH-1:0]   out_di,
  output logic [OUT_WIDTH-1:0][31:0]     out_inst,
  output fsq_idx_info_t [OUT_WIDTH-1:0]  out_fsq_info,
  input  logic                           out_stall,
  input  logic                           redirect,
  input  logic                           walk,
  output logic                           perf_walk_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(IN_WIDTH + 1);
  typedef logic [PW:0] ptr_t;

  decq_entry_t          mem_q [DEPTH];
  decq_entry_t          mem_d [DEPTH];
  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  ptr_t                 count_q, count_d;
  logic [OUT_WIDTH-1:0] out_en_q, out_en_d;
  decq_entry_t          out_entry_q [OUT_WIDTH];
  decq_entry_t          out_entry_d [OUT_WIDTH];
  logic                 perf_q, perf_d;

  decq_entry_t                 in_entry [IN_WIDTH];
  logic [IN_WIDTH-1:0][CW-1:0] enq_off;
  logic [CW-1:0]               enq_total;
  ptr_t                        free_slots;
  ptr_t                        enq_n;
  ptr_t                        deq_n;
  ptr_t                        avail;
  ptr_t                        k;
  ptr_t                        wptr;
  ptr_t                        rptr;
  logic                        flush;
  logic                        enq_fire;

  // Decode happens once, on the way in; the queue stores decoded entries.
  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      in_entry[i].di       = decode_inst(in_inst[i], in_iam[i], in_ipf[i]);
      in_entry[i].inst     = in_inst[i];
      in_entry[i].fsq_info = in_fsq_info[i];
    end
  end

  decq_compact #(.N(IN_WIDTH)) u_enq_compact (
    .mask   (in_en),
    .offset (enq_off),
    .total  (enq_total)
  );

  // Ready looks only at the registered count so fetch never sees a path
  // through this cycle's dequeue decision.
  assign free_slots = ptr_t'(DEPTH) - count_q;
  assign in_ready   = free_slots >= ptr_t'(IN_WIDTH);
  assign flush      = redirect | walk;
  assign enq_fire   = in_ready && (|in_en) && !flush;
  assign enq_n      = enq_fire ? ptr_t'(enq_total) : '0;

`ifdef DECQ_BYPASS_EN
  logic        byp_fire;
  decq_entry_t byp_entry [OUT_WIDTH];

  // With an empty queue the bundle is still written into the queue, but the
  // head jumps past the lanes that go straight to the output register.
  assign byp_fire = enq_fire && (count_q == '0) && !out_stall;

  always_comb begin
    for (int l = 0; l < OUT_WIDTH; l++) begin
      byp_entry[l] = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_en[i] && (ptr_t'(enq_off[i]) == ptr_t'(l))) begin
          byp_entry[l] = in_entry[i];
        end
      end
    end
  end
`endif

  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    out_en_d    = out_en_q;
    out_entry_d = out_entry_q;
    perf_d      = walk && in_en[0];
    deq_n       = '0;
    avail       = count_q;
    wptr        = '0;
    rptr        = '0;

    if (enq_fire) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_en[i]) begin
          wptr = tail_q + ptr_t'(enq_off[i]);
          mem_d[wptr[PW-1:0]] = in_entry[i];
        end
      end
      tail_d = tail_q + enq_n;
    end

`ifdef DECQ_BYPASS_EN
    if (byp_fire) begin
      avail = enq_n;
    end
`endif

    k = (avail > ptr_t'(OUT_WIDTH)) ? ptr_t'(OUT_WIDTH) : avail;

    if (!out_stall) begin
      for (int l = 0; l < OUT_WIDTH; l++) begin
        out_en_d[l]    = ptr_t'(l) < k;
        rptr           = head_q + ptr_t'(l);
        out_entry_d[l] = mem_q[rptr[PW-1:0]];
`ifdef DECQ_BYPASS_EN
        if (byp_fire) begin
          out_entry_d[l] = byp_entry[l];
        end
`endif
      end
      deq_n  = k;
      head_d = head_q + k;
    end

    count_d = count_q + enq_n - deq_n;

    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      out_en_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      out_en_q <= '0;
      perf_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      out_en_q <= out_en_d;
      perf_q   <= perf_d;
    end
  end

  // Payload storage is qualified by the pointers and out_en, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q       <= mem_d;
    out_entry_q <= out_entry_d;
  end

  always_comb begin
    for (int l = 0; l < OUT_WIDTH; l++) begin
      out_di[l]       = out_entry_q[l].di;
      out_inst[l]     = out_entry_q[l].inst;
      out_fsq_info[l] = out_entry_q[l].fsq_info;
    end
  end

  assign out_en          = out_en_q;
  assign perf_walk_stall = perf_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int IW    = 4;
  localparam int OW    = 4;
  localparam int DEPTH = 16;
`ifdef DECQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [IW-1:0]           in_en;
  logic [IW-1:0][31:0]     in_inst;
  logic [IW-1:0]           in_iam;
  logic [IW-1:0]           in_ipf;
  fsq_idx_info_t [IW-1:0]  in_fsq_info;
  logic                    in_ready;
  logic [OW-1:0]           out_en;
  decode_info_t [OW-1:0]   out_di;
  logic [OW-1:0][31:0]     out_inst;
  fsq_idx_info_t [OW-1:0]  out_fsq_info;
  logic                    out_stall;
  logic                    redirect;
  logic                    walk;
  logic                    perf_walk_stall;

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  decq_entry_t fifo [$];
  decq_entry_t outv [$];
  bit          exp_perf;

  logic [6:0] opcs   [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
  fu_t        opc_fu [10] = '{FU_ALU, FU_ALU, FU_BRU, FU_BRU, FU_BRU,
                              FU_LDU, FU_STU, FU_ALU, FU_ALU, FU_CSR};
  bit         opc_wr [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 1};

  typedef struct {
    logic [3:0] en;
    bit         stall;
    bit         redir;
    bit         wk;
    logic [3:0] out_nb;
    logic [3:0] out_byp;
    bit         rdy;
    bit         perf;
  } vec_t;

  vec_t tv [17];

  decode_queue dut (
    .clk             (clk),
    .rst             (rst),
    .in_en           (in_en),
    .in_inst         (in_inst),
    .in_iam          (in_iam),
    .in_ipf          (in_ipf),
    .in_fsq_info     (in_fsq_info),
    .in_ready        (in_ready),
    .out_en          (out_en),
    .out_di          (out_di),
    .out_inst        (out_inst),
    .out_fsq_info    (out_fsq_info),
    .out_stall       (out_stall),
    .redirect        (redirect),
    .walk            (walk),
    .perf_walk_stall (perf_walk_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic decode_info_t ref_decode(input logic [31:0] inst, input logic iam,
                                              input logic ipf);
    decode_info_t d;
    bit known = 0;
    bit wr = 0;
    d         = '0;
    d.rd      = inst[11:7];
    d.rs1     = inst[19:15];
    d.rs2     = inst[24:20];
    d.exc_iam = iam;
    d.exc_ipf = ipf;
    for (int j = 0; j < 10; j++) begin
      if (inst[6:0] == opcs[j]) begin
        known = 1;
        d.fu  = opc_fu[j];
        wr    = opc_wr[j];
      end
    end
    if (inst[6:0] == 7'b0110011 && inst[31:25] == 7'b0000001) d.fu = FU_MDU;
    d.illegal = !known;
    if (iam || ipf) begin
      d.fu      = FU_NONE;
      d.illegal = 1'b0;
      wr        = 0;
    end
    d.rd_wen = wr && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic decq_entry_t make_entry(input int i);
    decq_entry_t e;
    e.di       = ref_decode(in_inst[i], in_iam[i], in_ipf[i]);
    e.inst     = in_inst[i];
    e.fsq_info = in_fsq_info[i];
    return e;
  endfunction

  task automatic gen_bundle();
    logic [31:0] inst;
    int sel;
    for (int i = 0; i < IW; i++) begin
      inst = $urandom;
      sel  = $urandom_range(0, 10);
      if (sel < 10) inst[6:0] = opcs[sel];
      if ($urandom_range(0, 3) == 0) inst[31:25] = 7'b0000001;
      in_inst[i]            = inst;
      in_iam[i]             = ($urandom_range(0, 15) == 0);
      in_ipf[i]             = ($urandom_range(0, 15) == 0);
      in_fsq_info[i].idx    = 6'(seq);
      in_fsq_info[i].offset = 4'(i);
    end
    seq++;
  endtask

  // Queue-level model of one clock edge, using the inputs present at the edge.
  function automatic void model_edge();
    decq_entry_t nw [$];
    if (!rst) begin
      fifo.delete();
      outv.delete();
      exp_perf = 0;
      return;
    end
    exp_perf = walk && in_en[0];
    if (redirect || walk) begin
      fifo.delete();
      outv.delete();
      return;
    end
    if ((DEPTH - fifo.size()) >= IW) begin
      for (int i = 0; i < IW; i++) if (in_en[i]) nw.push_back(make_entry(i));
    end
    if (BYP && !out_stall && fifo.size() == 0) begin
      fifo = nw;
      nw.delete();
    end
    if (!out_stall) begin
      outv.delete();
      while (outv.size() < OW && fifo.size() > 0) outv.push_back(fifo.pop_front());
    end
    foreach (nw[j]) fifo.push_back(nw[j]);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("out_en", 128'(out_en), 128'((1 << outv.size()) - 1));
    for (int l = 0; l < outv.size(); l++) begin
      check($sformatf("lane%0d", l), 128'({out_di[l], out_inst[l], out_fsq_info[l]}),
            128'(outv[l]));
    end
    check("in_ready", 128'(in_ready), 128'((DEPTH - fifo.size()) >= IW));
    check("perf_walk_stall", 128'(perf_walk_stall), 128'(exp_perf));
  endtask

  task automatic step(input logic [3:0] en, input bit stall, input bit redir, input bit wk,
                      input bit rn);
    in_en     = en;
    out_stall = stall;
    redirect  = redir;
    walk      = wk;
    rst       = rn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] en;
    bit         rdy;
    bit         stall;
    bit         redir;
    bit         wk;
    bit         rn;

    //            en     st re wk out_nb   out_byp  rdy perf
    tv[0]  = '{4'b1011, 0, 0, 0, 4'b0000, 4'b0111, 1, 0};
    tv[1]  = '{4'b0000, 0, 0, 0, 4'b0111, 4'b0000, 1, 0};
    tv[2]  = '{4'b1111, 1, 0, 0, 4'b0111, 4'b0000, 1, 0};
    tv[3]  = '{4'b1111, 1, 0, 0, 4'b0111, 4'b0000, 1, 0};
    tv[4]  = '{4'b1111, 1, 0, 0, 4'b0111, 4'b0000, 1, 0};
    tv[5]  = '{4'b1111, 1, 0, 0, 4'b0111, 4'b0000, 0, 0};
    tv[6]  = '{4'b1111, 1, 0, 0, 4'b0111, 4'b0000, 0, 0};
    tv[7]  = '{4'b0000, 0, 0, 0, 4'b1111, 4'b1111, 1, 0};
    tv[8]  = '{4'b0010, 0, 0, 0, 4'b1111, 4'b1111, 1, 0};
    tv[9]  = '{4'b1111, 0, 1, 0, 4'b0000, 4'b0000, 1, 0};
    tv[10] = '{4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 1, 0};
    tv[11] = '{4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 1, 0};
    tv[12] = '{4'b0001, 0, 0, 1, 4'b0000, 4'b0000, 1, 1};
    tv[13] = '{4'b1111, 1, 0, 1, 4'b0000, 4'b0000, 1, 1};
    tv[14] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0};
    tv[15] = '{4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 1, 0};
    tv[16] = '{4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 1, 0};

    gen_bundle();
    step(4'b0000, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);
    check("reset_out_en", 128'(out_en), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_perf", 128'(perf_walk_stall), 128'(0));

    for (int r = 0; r < 17; r++) begin
      gen_bundle();
      step(tv[r].en, tv[r].stall, tv[r].redir, tv[r].wk, 1);
      check($sformatf("tv%0d_out_en", r), 128'(out_en), 128'(BYP ? tv[r].out_byp : tv[r].out_nb));
      check($sformatf("tv%0d_in_ready", r), 128'(in_ready), 128'(tv[r].rdy));
      check($sformatf("tv%0d_perf", r), 128'(perf_walk_stall), 128'(tv[r].perf));
    end

    // Single-lane bundles with alternating stall: several trips round the ring.
    for (int j = 0; j < 40; j++) begin
      gen_bundle();
      step(4'b0001, (j % 2) == 1, 0, 0, 1);
    end
    for (int j = 0; j < 12; j++) step(4'b0000, 0, 0, 0, 1);

    // Reset for one edge in the middle of traffic, walk raised at the same time.
    for (int j = 0; j < 3; j++) begin
      gen_bundle();
      step(4'b1111, 1, 0, 0, 1);
    end
    gen_bundle();
    step(4'b1111, 0, 0, 1, 0);
    check("midrst_out_en", 128'(out_en), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_perf", 128'(perf_walk_stall), 128'(0));
    gen_bundle();
    step(4'b0101, 0, 0, 0, 1);
    check("postrst_out_en_a", 128'(out_en), 128'(BYP ? 4'b0011 : 4'b0000));
    step(4'b0000, 0, 0, 0, 1);
    check("postrst_out_en_b", 128'(out_en), 128'(BYP ? 4'b0000 : 4'b0011));

    // Random traffic; fetch holds its bundle while the queue is not ready.
    en = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      rdy = (DEPTH - fifo.size()) >= IW;
      if (rdy) begin
        en = 4'($urandom);
        gen_bundle();
      end
      stall = ($urandom_range(0, 9) < 4);
      redir = ($urandom_range(0, 119) == 0);
      wk    = ($urandom_range(0, 149) == 0);
      rn    = ($urandom_range(0, 699) != 0);
      step(en, stall, redir, wk, rn);
    end
    for (int j = 0; j < 8; j++) step(4'b0000, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
